// File: rtl/dragonfang_pkg.sv
// Shared types and helpers for the dragonfang lane execution/commit boundary.
package dragonfang_pkg;

   localparam int FU_ID_W        = 4;
   localparam int VREG_ADDR_W    = 16;
   localparam int VD_W           = 8;
   localparam int DEFAULT_NUM_FU = 4;

   // Result packet as produced by a functional unit.
   typedef struct packed {
      logic [FU_ID_W-1:0]     functional_unit_id;
      logic [VREG_ADDR_W-1:0] vector_destination_address;
      logic [VD_W-1:0]        vd;
   } execution_output_packet_t;

   // Packet as consumed by the commit stage.
   typedef struct packed {
      logic [VREG_ADDR_W-1:0] vector_destination_address;
      logic [VD_W-1:0]        vd;
   } commit_input_packet_t;

   // Width of a channel index for a given number of functional units.
   function automatic int commit_source_w(input int num_fu);
      return (num_fu > 1) ? $clog2(num_fu) : 1;
   endfunction

   typedef logic [commit_source_w(DEFAULT_NUM_FU)-1:0] commit_source_t;

   // Strip the routing id and keep the fields commit needs.
   function automatic commit_input_packet_t pack_execution_to_commit(
      input execution_output_packet_t pkt
   );
      commit_input_packet_t c;
      c.vector_destination_address = pkt.vector_destination_address;
      c.vd                         = pkt.vd;
      return c;
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// Per-channel packet FIFO: registered storage, combinational head read.
// Pointers carry one extra MSB so full and empty are distinguishable.
module commit_fifo
   import dragonfang_pkg::*;
#(
   parameter int  FIFO_DEPTH = 2,
   parameter type packet_t   = commit_input_packet_t
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  packet_t push_data,
   input  logic    pop,
   output packet_t head,
   output logic    empty,
   output logic    full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   packet_t       mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; both may move in the same cycle, keeping count and order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; data is not reset, emptiness is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/commit_arbiter.sv
// Collects result packets from NUM_FU functional units into per-unit FIFOs
// and forwards one per cycle to commit under round-robin arbitration.
// Packets arriving on the wrong port are consumed, dropped and flagged.
module commit_arbiter
   import dragonfang_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  execution_output_packet_t [NUM_FU-1:0] execution_output_packet,
   input  logic [NUM_FU-1:0]                    execution_valid,
   output logic [NUM_FU-1:0]                    execution_ready,
   output commit_input_packet_t                 commit_input_packet,
   output logic                                 commit_valid,
   input  logic                                 commit_ready,
   output logic [commit_source_w(NUM_FU)-1:0]   commit_source,
   output logic [NUM_FU-1:0]                    id_mismatch
);

   localparam int SRC_W = commit_source_w(NUM_FU);

   logic [NUM_FU-1:0]    id_ok;
   logic [NUM_FU-1:0]    fifo_push;
   logic [NUM_FU-1:0]    fifo_pop;
   logic [NUM_FU-1:0]    fifo_empty;
   logic [NUM_FU-1:0]    fifo_full;
   commit_input_packet_t push_pkt  [NUM_FU];
   commit_input_packet_t fifo_head [NUM_FU];

   logic [SRC_W-1:0]     rr_ptr;
   logic [SRC_W-1:0]     scan_idx;
   logic                 scan_found;
   logic                 lock_vld;
   logic [SRC_W-1:0]     lock_idx;
   logic [SRC_W-1:0]     grant_idx;
   logic                 commit_fire;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign id_ok[i]     = (execution_output_packet[i].functional_unit_id == FU_ID_W'(i));
      assign fifo_push[i] = execution_valid[i] && !fifo_full[i] && id_ok[i];
      assign push_pkt[i]  = pack_execution_to_commit(execution_output_packet[i]);

      commit_fifo #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .packet_t   (commit_input_packet_t)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (fifo_push[i]),
         .push_data (push_pkt[i]),
         .pop       (fifo_pop[i]),
         .head      (fifo_head[i]),
         .empty     (fifo_empty[i]),
         .full      (fifo_full[i])
      );
   end

   // Ready depends only on occupancy, never on a same-cycle pop.
   assign execution_ready = ~fifo_full;

   // Round-robin scan: first non-empty channel starting at rr_ptr.
   always_comb begin
      int idx;
      logic [SRC_W-1:0] idx_w;
      scan_found = 1'b0;
      scan_idx   = '0;
      idx        = 0;
      idx_w      = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         idx_w = SRC_W'(idx);
         if (!scan_found && !fifo_empty[idx_w]) begin
            scan_found = 1'b1;
            scan_idx   = idx_w;
         end
      end
   end

   // Output selection: a locked grant overrides the scan while commit stalls.
   always_comb begin
      grant_idx           = lock_vld ? lock_idx : scan_idx;
      commit_valid        = lock_vld || scan_found;
      commit_source       = '0;
      commit_input_packet = '0;
      if (commit_valid) begin
         commit_source       = grant_idx;
         commit_input_packet = fifo_head[grant_idx];
      end
      commit_fire = commit_valid && commit_ready;
      for (int i = 0; i < NUM_FU; i++) begin
         fifo_pop[i] = commit_fire && (grant_idx == SRC_W'(i));
      end
   end

   // Round-robin pointer and grant lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         lock_vld <= 1'b0;
         lock_idx <= '0;
      end else if (commit_fire) begin
         rr_ptr   <= (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
         lock_vld <= 1'b0;
      end else if (commit_valid) begin
         lock_vld <= 1'b1;
         lock_idx <= grant_idx;
      end
   end

   // Mismatch flag pulses the cycle after a wrong-port packet is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_mismatch <= '0;
      end else begin
         id_mismatch <= execution_valid & execution_ready & ~id_ok;
      end
   end

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed testbench for commit_arbiter (NUM_FU = 4, FIFO_DEPTH = 2).
module tb_commit_arbiter;
   import dragonfang_pkg::*;

   localparam int NUM_FU     = 4;
   localparam int FIFO_DEPTH = 2;

   logic                                 clk   = 1'b0;
   logic                                 rst_n = 1'b1;
   execution_output_packet_t [NUM_FU-1:0] exec_pkt;
   logic [NUM_FU-1:0]                    exec_valid;
   logic [NUM_FU-1:0]                    exec_ready;
   commit_input_packet_t                 commit_pkt;
   logic                                 commit_valid;
   logic                                 commit_ready;
   logic [1:0]                           commit_source;
   logic [NUM_FU-1:0]                    id_mismatch;

   int checks  = 0;
   int errors  = 0;
   int seen_a5 = 0;

   commit_arbiter #(
      .NUM_FU     (NUM_FU),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .execution_output_packet (exec_pkt),
      .execution_valid         (exec_valid),
      .execution_ready         (exec_ready),
      .commit_input_packet     (commit_pkt),
      .commit_valid            (commit_valid),
      .commit_ready            (commit_ready),
      .commit_source           (commit_source),
      .id_mismatch             (id_mismatch)
   );

   always #5 clk = ~clk;

   // Any appearance of the dropped packet at the commit port is an error.
   always @(negedge clk) begin
      if (rst_n && commit_valid && commit_pkt.vd == 8'hA5) seen_a5++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic execution_output_packet_t mk(input int fu, input int vd, input int addr);
      execution_output_packet_t p;
      p.functional_unit_id         = 4'(fu);
      p.vector_destination_address = 16'(addr);
      p.vd                         = 8'(vd);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exec_valid   = '0;
      exec_pkt     = '0;
      commit_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      #1;

      // Reset with all inputs active
      rst_n        = 1'b0;
      exec_valid   = 4'hF;
      for (int i = 0; i < NUM_FU; i++) exec_pkt[i] = mk(i, 8'h40 + i, i);
      commit_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", commit_valid, 0);
      check("rst_ready", exec_ready, 4'hF);
      check("rst_src", commit_source, 0);
      check("rst_pkt", commit_pkt, 0);
      check("rst_mism", id_mismatch, 0);
      rst_n        = 1'b1;
      exec_valid   = 4'b0010;
      exec_pkt[1]  = mk(1, 8'h11, 16'h0101);
      commit_ready = 1'b0;
      #1;
      check("pre_push_valid", commit_valid, 0);
      tick();
      check("lat_valid", commit_valid, 1);
      check("lat_src", commit_source, 1);
      check("lat_vd", commit_pkt.vd, 8'h11);
      check("lat_addr", commit_pkt.vector_destination_address, 16'h0101);
      exec_valid   = '0;
      commit_ready = 1'b1;
      tick();
      check("lat_drain", commit_valid, 0);

      // Round-robin fairness
      apply_reset();
      for (int i = 0; i < NUM_FU; i++) exec_pkt[i] = mk(i, 8'h10 + i, 0);
      exec_valid   = 4'hF;
      commit_ready = 1'b1;
      tick();
      for (int n = 0; n < 8; n++) begin
         check("rr_valid", commit_valid, 1);
         check("rr_src", commit_source, n % 4);
         check("rr_vd", commit_pkt.vd, 8'h10 + (n % 4));
         tick();
      end

      // Backpressure lock
      apply_reset();
      exec_pkt[2] = mk(2, 8'h22, 16'h0202);
      exec_valid  = 4'b0100;
      tick();
      exec_valid  = '0;
      for (int c = 1; c <= 5; c++) begin
         check("lock_valid", commit_valid, 1);
         check("lock_src", commit_source, 2);
         check("lock_vd", commit_pkt.vd, 8'h22);
         if (c == 2) begin
            exec_pkt[0] = mk(0, 8'h05, 16'h0005);
            exec_valid  = 4'b0001;
         end else begin
            exec_valid  = '0;
         end
         tick();
      end
      commit_ready = 1'b1;
      check("rel_src", commit_source, 2);
      tick();
      check("next_valid", commit_valid, 1);
      check("next_src", commit_source, 0);
      check("next_vd", commit_pkt.vd, 8'h05);
      tick();
      check("lock_drain", commit_valid, 0);

      // Full FIFO and pop freeing a slot
      apply_reset();
      exec_pkt[1] = mk(1, 8'h31, 16'h0031);
      exec_valid  = 4'b0010;
      tick();
      check("full_rdy1", exec_ready[1], 1);
      exec_pkt[1] = mk(1, 8'h32, 16'h0032);
      tick();
      check("full_rdy0", exec_ready[1], 0);
      exec_pkt[1] = mk(1, 8'h33, 16'h0033);
      tick();
      check("full_hold", exec_ready[1], 0);
      check("full_head", commit_pkt.vd, 8'h31);
      exec_valid   = '0;
      commit_ready = 1'b1;
      tick();
      check("pop_rdy", exec_ready[1], 1);
      check("pop_head", commit_pkt.vd, 8'h32);
      tick();
      check("no_third", commit_valid, 0);

      // Reset in mid-operation discards buffered packets at once
      commit_ready = 1'b0;
      exec_pkt[2]  = mk(2, 8'h44, 16'h0044);
      exec_valid   = 4'b0100;
      tick();
      exec_valid   = '0;
      check("mid_pre", commit_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", commit_valid, 0);
      check("mid_rst_rdy", exec_ready, 4'hF);
      tick();
      rst_n = 1'b1;

      // ID mismatch on channel 3, good packet on channel 0
      apply_reset();
      exec_pkt[3]  = mk(1, 8'hA5, 16'h00A5);
      exec_pkt[0]  = mk(0, 8'h0A, 16'h000A);
      exec_valid   = 4'b1001;
      commit_ready = 1'b1;
      check("mism_rdy", exec_ready, 4'hF);
      tick();
      exec_valid   = '0;
      check("mism_pulse", id_mismatch, 4'b1000);
      check("mism_valid", commit_valid, 1);
      check("mism_src", commit_source, 0);
      check("mism_vd", commit_pkt.vd, 8'h0A);
      tick();
      check("mism_clear", id_mismatch, 0);
      check("mism_drain", commit_valid, 0);
      tick();
      check("no_a5", seen_a5, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_arbiter.md
# commit_arbiter

Parametrised collector between the execution functional units and the commit stage of a dragonfang lane. It accepts result packets from `NUM_FU` functional units over independent valid/ready channels, buffers each in a per-unit FIFO, and forwards one packet per cycle to commit under round-robin arbitration. Each accepted packet is checked against its port index, and mismatched packets are dropped and flagged.

## Interface
- `NUM_FU`, default 4: number of functional-unit input channels; must be ≥ 2.
- `FIFO_DEPTH`, default 2: entries per channel FIFO; must be a power of two and ≥ 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `execution_output_packet` input, `execution_output_packet_t [NUM_FU-1:0]`: one result packet per functional unit.
- `execution_valid` input, `[NUM_FU-1:0]`: per-channel packet valid.
- `execution_ready` output, `[NUM_FU-1:0]`: per-channel ready, high when that FIFO is not full.
- `commit_input_packet` output, `commit_input_packet_t`: head packet of the granted channel.
- `commit_valid` output, 1 bit: `commit_input_packet` is valid.
- `commit_ready` input, 1 bit: the commit stage accepts the packet.
- `commit_source` output, `$clog2(NUM_FU)` bits: index of the granted channel.
- `id_mismatch` output, `[NUM_FU-1:0]`: one-cycle pulse per dropped packet.

## Operation
- Input handshake: channel i transfers when `execution_valid[i] && execution_ready[i]`.
- `execution_ready[i]` is `!full[i]`. It does not depend on a same-cycle pop, so a full FIFO never accepts.
- Port check on every transfer:
  - If `functional_unit_id == i`, the packet is converted to `commit_input_packet_t` (copy `vector_destination_address` and `vd`) and pushed.
  - Otherwise the packet is consumed but not stored, and `id_mismatch[i]` pulses on the next cycle.
- Arbitration:
  - Round-robin pointer `rr_ptr` is reset to 0.
  - The grant goes to the first non-empty channel scanning `rr_ptr, rr_ptr+1, …` modulo `NUM_FU`.
- Output handshake:
  - `commit_valid` is high when any FIFO is non-empty.
  - A transfer occurs on `commit_valid && commit_ready`: the granted FIFO pops and `rr_ptr` becomes (granted index + 1) mod `NUM_FU`.
- Stall rule: while `commit_valid && !commit_ready`, the grant is locked. `commit_source` and `commit_input_packet` hold stable even if higher-priority channels fill. The lock releases on the transfer cycle.
- When `commit_valid` is low, `commit_input_packet` is `'0` and `commit_source` is 0.
- FIFO pointers use `$clog2(FIFO_DEPTH)+1` bits. The MSB distinguishes full from empty, and the pointers wrap naturally.
- Simultaneous push and pop on the same non-full, non-empty FIFO leaves the count unchanged and keeps order.

## Timing
- Reset values, all asynchronous on `rst_n` low:
  - FIFOs empty, `rr_ptr` = 0.
  - `execution_ready` all ones.
  - `commit_valid` = 0, `commit_input_packet` = `'0`, `commit_source` = 0, `id_mismatch` = 0.
- Reset asserted mid-operation discards all buffered packets immediately.
- Latency: a packet pushed at edge t is visible at the output from cycle t+1 (registered storage, combinational head read). This is 1 cycle minimum.
- Throughput: one commit per cycle. Each channel can sustain one packet per cycle when `FIFO_DEPTH` ≥ 2 and the channel is granted every cycle.
- The output path is combinational from FIFO state and `rr_ptr`. `commit_ready` affects only state updates, never same-cycle outputs.
- `id_mismatch` is registered: it pulses in the cycle after the offending transfer.

## Structure
- `dragonfang_pkg` gets a new `commit_source_t` width helper and the shared `pack_execution_to_commit` function. The existing `execution_output_packet_t` and `commit_input_packet_t` are reused unchanged.
- Sub-module `commit_fifo` (parameters `FIFO_DEPTH` and the packet type), instantiated `NUM_FU` times. The arbiter, grant lock and `rr_ptr` live in `commit_arbiter`.

## Test plan
- Reset: hold `rst_n` low with all inputs active, release.
  - During reset: `commit_valid` = 0 and `execution_ready` = 4'b1111.
  - After release: the first pushed packet appears 1 cycle later.
- Round-robin fairness: all four channels continuously valid with correct IDs, `commit_ready` = 1. Required `commit_source` sequence: 0,1,2,3,0,1,….
- Backpressure lock: channel 2 holds one packet, `commit_ready` = 0 for 5 cycles, channel 0 is pushed in cycle 2.
  - `commit_source` stays 2 with the packet stable for all 5 cycles.
  - After `commit_ready` rises, channel 0 is granted next.
- Full FIFO: `FIFO_DEPTH` = 2, push 2 packets on channel 1 with `commit_ready` = 0. Required: `execution_ready[1]` = 0 and a third packet is not accepted.
- Pop frees a slot: in the full-FIFO setup, raise `commit_ready`. Required: `execution_ready[1]` returns to 1 the cycle after the pop.
- ID mismatch: channel 3 sends `functional_unit_id` = 1, `vd` = 8'hA5.
  - `id_mismatch[3]` pulses for exactly one cycle.
  - No packet with `vd` = 8'hA5 ever reaches commit.
  - Other channels are unaffected.
